// File: rtl/cluster_event_dc_pkg.sv
// Shared definitions for the event dual-clock token ring (SoC-side TX and cluster-side RX).
// Ring vectors are handled at the maximum legal width so that one helper set serves every instance.
package cluster_event_dc_pkg;

  localparam int unsigned DEFAULT_BUFFER_WIDTH = 8;
  localparam int unsigned DEFAULT_EVNT_WIDTH   = 8;
  localparam int unsigned MAX_BUFFER_WIDTH     = 16;

  typedef logic [MAX_BUFFER_WIDTH-1:0] ring_vec_t;
  typedef logic [$clog2(MAX_BUFFER_WIDTH)-1:0] ring_idx_t;

  // Index of the lowest set bit; a zero vector maps to index 0.
  function automatic ring_idx_t onehot_to_idx(input ring_vec_t v);
    onehot_to_idx = '0;
    for (int i = MAX_BUFFER_WIDTH - 1; i >= 0; i--) begin
      if (v[i]) onehot_to_idx = ring_idx_t'(i);
    end
  endfunction

  // Rotate left by one inside the low `width` bits; bits above `width` come out zero.
  function automatic ring_vec_t rotl1(input ring_vec_t v, input int unsigned width);
    ring_vec_t r;
    r = '0;
    for (int i = 0; i < MAX_BUFFER_WIDTH; i++) begin
      if (i == int'(width) - 1) r[0] = v[i];
      else if (i < int'(width) - 1) r[(i + 1) % MAX_BUFFER_WIDTH] = v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cluster_event_dc_tx_if.sv
// Upstream event handshake into the SoC-side token-ring transmitter.
interface cluster_event_dc_tx_if
  import cluster_event_dc_pkg::*;
#(
    parameter int unsigned EVNT_WIDTH = DEFAULT_EVNT_WIDTH
);
    logic                  evt_valid;
    logic [EVNT_WIDTH-1:0] evt_data;
    logic                  evt_ready;

    modport master (output evt_valid, output evt_data, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_data, output evt_ready);
endinterface

// File: rtl/cluster_event_dc_rp_sync.sv
// CDC synchronizer: two flops per bit bringing the cluster read pointer into the SoC clock domain.
// Only legal on a gray/one-hot style bus where at most one bit moves per source update.
module cluster_event_dc_rp_sync #(
    parameter int unsigned     WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] data_async,
    output logic [WIDTH-1:0] data_sync
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: non-blocking assignments make both stages sample the pre-edge values, giving a true 2-flop chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= data_async;
            sync_q <= meta_q;
        end
    end

    assign data_sync = sync_q;

endmodule

// File: rtl/cluster_event_dc_tx.sv
// SoC-side transmitter of the event token ring: writes events into slots behind a one-hot write token
// that chases the synchronized cluster read pointer; one slot is always kept empty to tell full from empty.
module cluster_event_dc_tx
  import cluster_event_dc_pkg::*;
#(
    parameter int unsigned BUFFER_WIDTH = DEFAULT_BUFFER_WIDTH,
    parameter int unsigned EVNT_WIDTH   = DEFAULT_EVNT_WIDTH
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    cluster_event_dc_tx_if.slave               evt,
    output logic [BUFFER_WIDTH-1:0]            events_wt_o,
    input  logic [BUFFER_WIDTH-1:0]            events_rp_i,
    output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o,
    output logic [$clog2(BUFFER_WIDTH)-1:0]    fill_level_o,
    output logic                               rp_error_o
);

    localparam int unsigned FILL_WIDTH = $clog2(BUFFER_WIDTH);

    logic [BUFFER_WIDTH-1:0]            rp_sync;
    logic [BUFFER_WIDTH-1:0]            token_q;
    logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] da_q;
    logic [FILL_WIDTH-1:0]              fill_q;
    logic                               err_q;

    ring_vec_t             token_ext;
    ring_vec_t             rp_ext;
    ring_vec_t             token_rot_ext;
    ring_idx_t             tok_idx;
    ring_idx_t             rp_idx;
    logic [FILL_WIDTH-1:0] fill_next;
    logic                  rp_onehot;
    logic                  full;
    logic                  accept;

    cluster_event_dc_rp_sync #(
        .WIDTH     (BUFFER_WIDTH),
        .RESET_VAL (BUFFER_WIDTH'(1))
    ) u_rp_sync (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .data_async (events_rp_i),
        .data_sync  (rp_sync)
    );

    // NOTE: every output of this block gets a value before any condition, so no latch can be inferred.
    always_comb begin
        token_ext                      = '0;
        token_ext[BUFFER_WIDTH-1:0]    = token_q;
        rp_ext                         = '0;
        rp_ext[BUFFER_WIDTH-1:0]       = rp_sync;
        token_rot_ext                  = rotl1(token_ext, BUFFER_WIDTH);
        tok_idx                        = onehot_to_idx(token_ext);
        rp_idx                         = onehot_to_idx(rp_ext);
        fill_next = (tok_idx >= rp_idx)
                  ? FILL_WIDTH'(tok_idx - rp_idx)
                  : FILL_WIDTH'(5'(tok_idx) + 5'(BUFFER_WIDTH) - 5'(rp_idx));
    end

    assign rp_onehot = (rp_sync != '0) && ((rp_sync & (rp_sync - BUFFER_WIDTH'(1))) == '0);
    assign full      = (token_rot_ext == rp_ext);

    // Ready looks only at registered state, so upstream valid never loops back into it.
    assign evt.evt_ready = rst_ni & ~full & ~err_q;
    assign accept        = evt.evt_valid & evt.evt_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            token_q <= BUFFER_WIDTH'(1);
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            fill_q <= fill_next;
            if (!rp_onehot) err_q <= 1'b1;
            if (accept) token_q <= token_rot_ext[BUFFER_WIDTH-1:0];
        end
    end

    // NOTE: the slot storage is reset because the cluster side reads it combinationally across the clock boundary.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            da_q <= '0;
        end else begin
            for (int k = 0; k < BUFFER_WIDTH; k++) begin
                if (accept && token_q[k]) da_q[k*EVNT_WIDTH +: EVNT_WIDTH] <= evt.evt_data;
            end
        end
    end

    assign events_wt_o  = token_q;
    assign events_da_o  = da_q;
    assign fill_level_o = fill_q;
    assign rp_error_o   = err_q;

endmodule

// File: doc/cluster_event_dc_tx.md
CLUSTER_EVENT_DC_TX -- requirements
Module: cluster_event_dc_tx

Interface
REQ-001 The block SHALL have parameter BUFFER_WIDTH, default 8, giving the number of token-ring slots (legal range 4..16).
REQ-002 The block SHALL have parameter EVNT_WIDTH, default 8, giving the event ID width in bits.
REQ-003 The block SHALL have one clock and one reset: clk_i is the SoC-side clock; rst_ni is asynchronous, active-low.
REQ-004 clk_i  in  1  SoC clock; all state updates on its rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 evt_valid_i  in  1  upstream event offered.
REQ-007 evt_data_i  in  EVNT_WIDTH  event ID.
REQ-008 evt_ready_o  out  1  slot free; an event transfers when valid and ready are both high.
REQ-009 events_wt_o  out  BUFFER_WIDTH  one-hot write token towards the cluster domain.
REQ-010 events_rp_i  in  BUFFER_WIDTH  one-hot read pointer from the cluster domain (asynchronous).
REQ-011 events_da_o  out  BUFFER_WIDTH*EVNT_WIDTH  slot storage; slot k occupies bits [k*EVNT_WIDTH +: EVNT_WIDTH].
REQ-012 fill_level_o  out  $clog2(BUFFER_WIDTH)  occupied slots as seen by the SoC side.
REQ-013 rp_error_o  out  1  sticky: a synchronized read pointer was not one-hot.

Function
REQ-014 events_rp_i SHALL pass through a 2-flop synchronizer before any use; the result is rp_sync.
REQ-015 The write token SHALL be one-hot and SHALL rotate left by one position (bit BUFFER_WIDTH-1 wraps to bit 0) on every accepted transfer.
REQ-016 On an accepted transfer, evt_data_i SHALL be written into the slot selected by the current token in the same edge that the token advances.
REQ-017 Unselected slots SHALL hold their value; no slot SHALL change without an accepted transfer.
REQ-018 Full: rotate-left-by-one of the token equals rp_sync; usable capacity is BUFFER_WIDTH-1.
REQ-019 Empty: token equals rp_sync.
REQ-020 evt_ready_o SHALL be low when full, when rp_error_o is high, or during reset; otherwise high. It is combinational from registered state only, with no path from evt_valid_i.
REQ-021 A transfer offered while full SHALL be held off; valid held with stable data until ready rises is the upstream obligation.
REQ-022 fill_level_o SHALL equal (index(token) - index(rp_sync)) mod BUFFER_WIDTH, registered, with a latency of one cycle after a token or rp_sync change.
REQ-023 A simultaneous accept and rp_sync advance in the same cycle SHALL leave fill_level_o unchanged.
REQ-024 If rp_sync is zero or has more than one bit set, rp_error_o SHALL set on the next edge and stay set until reset; the token SHALL freeze while it is set.
REQ-025 Accept-to-token-visible latency SHALL be one cycle; data for a slot is registered no later than its token bit.

Reset
REQ-026 Reset SHALL set the token to bit 0 only, both synchronizer stages to bit 0 only, all slots to 0, fill_level_o to 0, rp_error_o to 0, and evt_ready_o to 0 while rst_ni is low.
REQ-027 Reset asserted mid-transfer SHALL discard the transfer in flight; after release, the first accept writes slot 0.
REQ-028 Both sides SHALL be reset together; skew between them is a system-level constraint, not a checked condition.

Structure
REQ-029 A shared package cluster_event_dc_pkg SHALL hold the default BUFFER_WIDTH/EVNT_WIDTH values and one-hot-to-index and rotate functions, reused by the cluster-side receiver.
REQ-030 The synchronizer SHALL be one sub-module, cluster_event_dc_rp_sync (2 flops per bit, reset value parameterised), marked for CDC tools; everything else is flat.

Verification
REQ-031 Reset, then 7 back-to-back events 0x01..0x07 with rp held at 0x01 -> ready drops after the 7th accept, token = 0x80, fill_level = 7, slots 0..6 = 0x01..0x07.
REQ-032 From full, advance rp to 0x02 -> after 2 sync cycles plus 1 cycle, ready = 1 and fill = 6; next event 0xAA lands in slot 7 and the token wraps to 0x01.
REQ-033 Accept an event in the same cycle that rp_sync advances -> fill_level unchanged, no slot lost or overwritten.
REQ-034 Drive rp = 0x03 -> rp_error_o = 1 after 3 edges, ready = 0 and token frozen; rp_error_o stays set after rp is corrected, clears only on reset.
REQ-035 Assert rst_ni low for one cycle while valid = 1 at token 0x08 -> token = 0x01, slots cleared, ready = 0 during reset, first post-reset event in slot 0.
REQ-036 Random valid/rp stimulus with a cluster-side reference model on an unrelated clock ratio (e.g. 3:7) -> every event received exactly once, in order, no overflow.
